// File: rtl/pipelined_add_sub_pkg.sv
// Types and helpers shared by the pipelined adder/subtractor.
`include "alu_defs.vh"

package pipelined_add_sub_pkg;

  typedef enum logic {
    ALU_ADD = `ALU_OP_ADD,
    ALU_SUB = `ALU_OP_SUB
  } alu_op_e;

  localparam int unsigned FLAG_ZF  = `ALU_FLAG_ZF;
  localparam int unsigned FLAG_SF  = `ALU_FLAG_SF;
  localparam int unsigned FLAG_OF  = `ALU_FLAG_OF;
  localparam int unsigned FLAG_CF  = `ALU_FLAG_CF;
  localparam int unsigned FLAG_NUM = 32'd4;

  typedef logic [FLAG_NUM-1:0] flags_t;

  // A subtract reports borrow, which is the inverted carry out.
  function automatic logic carry_flag(input logic cout, input alu_op_e op);
    return cout ^ (op == ALU_SUB);
  endfunction

  function automatic logic overflow_flag(input logic c_msb, input logic cout);
    return c_msb ^ cout;
  endfunction

endpackage

// File: rtl/alu_defs.vh
// Shared ALU encodings: operation select and condition-code flag bit positions.
`ifndef ALU_DEFS_VH
`define ALU_DEFS_VH

`define ALU_OP_ADD 1'b0
`define ALU_OP_SUB 1'b1

`define ALU_FLAG_ZF 2'd0
`define ALU_FLAG_SF 2'd1
`define ALU_FLAG_OF 2'd2
`define ALU_FLAG_CF 2'd3

`endif

// File: rtl/pipelined_add_sub_add_chunk.sv
// Combinational W-bit ripple-carry adder built from gate primitives.
module add_chunk #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output wire  [W-1:0] y,
  output wire          cout,
  output wire          c_msb
);

  wire [W:0] c_w;

  assign c_w[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_bit
    wire p_w;
    wire g_w;
    wire pc_w;
    xor u_p  (p_w, a[i], b[i]);
    xor u_y  (y[i], p_w, c_w[i]);
    and u_g  (g_w, a[i], b[i]);
    and u_pc (pc_w, p_w, c_w[i]);
    or  u_c  (c_w[i+1], g_w, pc_w);
  end

  assign cout  = c_w[W];
  assign c_msb = c_w[W-1];

endmodule

// File: rtl/pipelined_add_sub.sv
// Pipelined two's-complement add/sub: one CHUNK of the carry chain per stage,
// global stall driven by the output handshake, flags decoded from the last stage.
module pipelined_add_sub
  import pipelined_add_sub_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_zf,
  output logic             out_sf,
  output logic             out_of,
  output logic             out_cf,
  output logic [TAG_W-1:0] out_tag
);

  localparam int CHUNK = WIDTH / STAGES;

  logic             adv_s;
  flags_t           flags_s;

  logic             valid_r [STAGES];
  logic [WIDTH-1:0] res_r   [STAGES];
  logic [WIDTH-1:0] a_r     [STAGES];
  logic [WIDTH-1:0] b_r     [STAGES];
  logic             carry_r [STAGES];
  logic             cmsb_r  [STAGES];
  logic             sub_r   [STAGES];
  logic [TAG_W-1:0] tag_r   [STAGES];

  logic             valid_nxt_s [STAGES];
  logic [WIDTH-1:0] res_nxt_s   [STAGES];
  logic [WIDTH-1:0] a_nxt_s     [STAGES];
  logic [WIDTH-1:0] b_nxt_s     [STAGES];
  logic             carry_nxt_s [STAGES];
  logic             cmsb_nxt_s  [STAGES];
  logic             sub_nxt_s   [STAGES];
  logic [TAG_W-1:0] tag_nxt_s   [STAGES];

  assign adv_s    = !valid_r[STAGES-1] || out_ready;
  assign in_ready = adv_s && !rst;

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    logic [WIDTH-1:0] op_a_s;
    logic [WIDTH-1:0] op_b_s;
    logic [WIDTH-1:0] res_in_s;
    logic             cin_s;
    logic             vin_s;
    logic             sub_s;
    logic [TAG_W-1:0] tag_s;
    logic [CHUNK-1:0] sum_s;
    logic             cout_s;
    logic             cmsb_s;

    // Stage 0 conditions B once; later stages consume skewed, already-conditioned operands.
    if (g == 0) begin : g_head
      assign sub_s    = (alu_op_e'(in_sub) == ALU_SUB);
      assign op_a_s   = in_a;
      assign op_b_s   = in_b ^ {WIDTH{sub_s}};
      assign cin_s    = sub_s;
      assign vin_s    = in_valid;
      assign tag_s    = in_tag;
      assign res_in_s = {WIDTH{1'b0}};
    end else begin : g_body
      assign sub_s    = sub_r[g-1];
      assign op_a_s   = a_r[g-1];
      assign op_b_s   = b_r[g-1];
      assign cin_s    = carry_r[g-1];
      assign vin_s    = valid_r[g-1];
      assign tag_s    = tag_r[g-1];
      assign res_in_s = res_r[g-1];
    end

    add_chunk #(.W(CHUNK)) u_add (
      .a     (op_a_s[g*CHUNK +: CHUNK]),
      .b     (op_b_s[g*CHUNK +: CHUNK]),
      .cin   (cin_s),
      .y     (sum_s),
      .cout  (cout_s),
      .c_msb (cmsb_s)
    );

    // Upper result chunks are still zero here, so OR-ing in the new chunk is exact.
    assign res_nxt_s[g]   = res_in_s | (WIDTH'(sum_s) << (g * CHUNK));
    assign valid_nxt_s[g] = vin_s;
    assign a_nxt_s[g]     = op_a_s;
    assign b_nxt_s[g]     = op_b_s;
    assign carry_nxt_s[g] = cout_s;
    assign cmsb_nxt_s[g]  = cmsb_s;
    assign sub_nxt_s[g]   = sub_s;
    assign tag_nxt_s[g]   = tag_s;
  end

  // Stage registers: clear on reset, all advance together or all hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        valid_r[i] <= 1'b0;
        res_r[i]   <= {WIDTH{1'b0}};
        a_r[i]     <= {WIDTH{1'b0}};
        b_r[i]     <= {WIDTH{1'b0}};
        carry_r[i] <= 1'b0;
        cmsb_r[i]  <= 1'b0;
        sub_r[i]   <= 1'b0;
        tag_r[i]   <= {TAG_W{1'b0}};
      end
    end else if (adv_s) begin
      for (int i = 0; i < STAGES; i++) begin
        valid_r[i] <= valid_nxt_s[i];
        res_r[i]   <= res_nxt_s[i];
        a_r[i]     <= a_nxt_s[i];
        b_r[i]     <= b_nxt_s[i];
        carry_r[i] <= carry_nxt_s[i];
        cmsb_r[i]  <= cmsb_nxt_s[i];
        sub_r[i]   <= sub_nxt_s[i];
        tag_r[i]   <= tag_nxt_s[i];
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        valid_r[i] <= valid_r[i];
      end
    end
  end

  // Condition codes decoded from the final stage register.
  always_comb begin
    flags_s          = {FLAG_NUM{1'b0}};
    flags_s[FLAG_ZF] = (res_r[STAGES-1] == {WIDTH{1'b0}});
    flags_s[FLAG_SF] = res_r[STAGES-1][WIDTH-1];
    flags_s[FLAG_OF] = overflow_flag(cmsb_r[STAGES-1], carry_r[STAGES-1]);
    flags_s[FLAG_CF] = carry_flag(carry_r[STAGES-1], alu_op_e'(sub_r[STAGES-1]));
  end

  assign out_valid = valid_r[STAGES-1];
  assign out_y     = res_r[STAGES-1];
  assign out_tag   = tag_r[STAGES-1];
  assign out_zf    = flags_s[FLAG_ZF];
  assign out_sf    = flags_s[FLAG_SF];
  assign out_of    = flags_s[FLAG_OF];
  assign out_cf    = flags_s[FLAG_CF];

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Directed scoreboard bench for pipelined_add_sub (WIDTH=64, STAGES=4).
module tb_pipelined_add_sub;

  localparam int WIDTH  = 64;
  localparam int STAGES = 4;
  localparam int TAG_W  = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_sub;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic             out_zf;
  logic             out_sf;
  logic             out_of;
  logic             out_cf;
  logic [TAG_W-1:0] out_tag;

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic             zf;
    logic             sf;
    logic             of;
    logic             cf;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  pipelined_add_sub #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_zf    (out_zf),
    .out_sf    (out_sf),
    .out_of    (out_of),
    .out_cf    (out_cf),
    .out_tag   (out_tag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic sub, input logic [TAG_W-1:0] tag);
    exp_t         e;
    logic [WIDTH:0] s;
    if (sub) begin
      e.y  = a - b;
      e.cf = (a < b);
      e.of = (a[WIDTH-1] != b[WIDTH-1]) && (e.y[WIDTH-1] != a[WIDTH-1]);
    end else begin
      s    = {1'b0, a} + {1'b0, b};
      e.y  = s[WIDTH-1:0];
      e.cf = s[WIDTH];
      e.of = (a[WIDTH-1] == b[WIDTH-1]) && (e.y[WIDTH-1] != a[WIDTH-1]);
    end
    e.zf  = (e.y == '0);
    e.sf  = e.y[WIDTH-1];
    e.tag = tag;
    return e;
  endfunction

  task automatic chkw(input string name, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic chk1(input string name, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", name, obs, exp);
    end
  endtask

  // Handshakes are decided between the falling edge and the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (out_valid && out_ready) begin
      chk1("sb_nonempty", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chkw("out_y", out_y, e.y);
        chkw("flags", WIDTH'({out_zf, out_sf, out_of, out_cf}), WIDTH'({e.zf, e.sf, e.of, e.cf}));
        chkw("out_tag", WIDTH'(out_tag), WIDTH'(e.tag));
      end
    end
    if (in_valid && in_ready) begin
      sb.push_back(model(in_a, in_b, in_sub, in_tag));
    end
  end

  task automatic drive(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic sub, input logic [TAG_W-1:0] tag);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_sub   = sub;
    in_tag   = tag;
  endtask

  // Issue one op at a falling edge and confirm it appears exactly STAGES cycles later.
  task automatic lat_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic sub, input logic [TAG_W-1:0] tag);
    drive(a, b, sub, tag);
    #1;
    chk1("lat_in_ready", in_ready, 1'b1);
    for (int n = 1; n <= STAGES; n++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk1("lat_out_valid", out_valid, (n == STAGES));
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      #3;
      if (sb.size() == 0 && !out_valid) done = 1'b1;
    end
    chk1("drain_done", done, 1'b1);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_sub    = 1'b0;
    in_tag    = '0;
    out_ready = 1'b1;
    #1;
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_in_ready", in_ready, 1'b0);
    chkw("rst_out_y", out_y, 64'h0);
    chkw("rst_out_tag", WIDTH'(out_tag), 64'h0);
    chkw("rst_flags", WIDTH'({out_zf, out_sf, out_of, out_cf}), 64'h8);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Carry ripples through every chunk to give zero.
    lat_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 4'd3);
    chkw("t1_y", out_y, 64'h0);
    chk1("t1_zf", out_zf, 1'b1);
    chk1("t1_cf", out_cf, 1'b1);
    chk1("t1_of", out_of, 1'b0);
    chkw("t1_tag", WIDTH'(out_tag), 64'd3);
    drain();

    lat_op(64'd5, 64'd7, 1'b1, 4'd4);
    chkw("t2_y", out_y, 64'hFFFF_FFFF_FFFF_FFFE);
    chk1("t2_sf", out_sf, 1'b1);
    chk1("t2_cf", out_cf, 1'b1);
    drain();

    lat_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 4'd5);
    chk1("t3a_of", out_of, 1'b1);
    chk1("t3a_cf", out_cf, 1'b0);
    drain();
    lat_op(64'h8000_0000_0000_0000, 64'd1, 1'b1, 4'd6);
    chkw("t3b_y", out_y, 64'h7FFF_FFFF_FFFF_FFFF);
    chk1("t3b_of", out_of, 1'b1);
    chk1("t3b_cf", out_cf, 1'b0);
    drain();

    // Back-to-back stream: results on eight consecutive cycles.
    for (int n = 0; n <= 12; n++) begin
      if (n < 8) drive(WIDTH'(n), 64'h0000_0001_0000_0000, 1'b0, TAG_W'(n));
      else in_valid = 1'b0;
      #1;
      chk1("t4_out_valid", out_valid, (n >= 4 && n <= 11));
      @(negedge clk);
    end
    drain();

    // Fill the pipe with the output blocked, then stall for three cycles.
    out_ready = 1'b0;
    e0 = model(64'd100, 64'd33, 1'b1, 4'd8);
    for (int n = 0; n <= 6; n++) begin
      if (n == 0) drive(64'd100, 64'd33, 1'b1, 4'd8);
      else if (n <= 4) drive(WIDTH'(n * 1000), 64'hFFFF_0000_0000_0000 + WIDTH'(n), n[0], TAG_W'(8 + n));
      #1;
      if (n >= 4) begin
        chk1("t5_in_ready", in_ready, 1'b0);
        chk1("t5_out_valid", out_valid, 1'b1);
        chkw("t5_out_y", out_y, e0.y);
        chkw("t5_out_tag", WIDTH'(out_tag), WIDTH'(e0.tag));
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    drain();

    // Reset with three ops in flight, one of them already on the output.
    for (int n = 0; n < 3; n++) begin
      drive(WIDTH'(n + 50), WIDTH'(n + 7), 1'b0, TAG_W'(n + 1));
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    #1;
    chk1("t6_rst_out_valid", out_valid, 1'b0);
    chk1("t6_rst_in_ready", in_ready, 1'b0);
    chkw("t6_rst_out_y", out_y, 64'h0);
    chkw("t6_rst_out_tag", WIDTH'(out_tag), 64'h0);
    chk1("t6_rst_zf", out_zf, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      #1;
      chk1("t6_no_stale", out_valid, 1'b0);
    end
    @(negedge clk);
    lat_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 4'd9);
    chkw("t6_y", out_y, 64'h2222_2222_2222_2211);
    chkw("t6_tag", WIDTH'(out_tag), 64'd9);
    drain();

    chk1("sb_empty", sb.size() == 0, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_add_sub.md
Name: pipelined_add_sub

Overview:
Parametrised, pipelined two's-complement adder/subtractor for the execute stage. Generalises the flat 64-bit ripple adder: configurable width and pipeline depth, add/sub mode, condition-code flags (ZF/SF/OF/CF) and an in-order tag. The carry chain is split into STAGES chunks, one chunk per pipeline stage, with valid/ready handshakes on both sides.

Parameters:
WIDTH, 64, operand/result width in bits; must be divisible by STAGES.
STAGES, 4, number of pipeline stages (1..8); each stage resolves CHUNK = WIDTH/STAGES bits.
TAG_W, 4, width of the sideband tag carried alongside each operation.

Ports:
clk  input  1  clock; all registers update on the rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  operand set on in_a/in_b/in_sub/in_tag is valid.
in_ready  output  1  block can accept an input this cycle.
in_a  input  WIDTH  operand A.
in_b  input  WIDTH  operand B.
in_sub  input  1  0 = A+B, 1 = A-B.
in_tag  input  TAG_W  opaque tag, returned unchanged with the result.
out_valid  output  1  result, flags and tag are valid.
out_ready  input  1  consumer accepts the result this cycle.
out_y  output  WIDTH  result.
out_zf  output  1  result == 0.
out_sf  output  1  out_y[WIDTH-1].
out_of  output  1  signed overflow.
out_cf  output  1  add: carry out of MSB; sub: borrow (inverted carry out).
out_tag  output  TAG_W  tag of this result.

Behaviour:
- Sub: B is bitwise inverted and carry-in is 1. Add: B is passed through and carry-in is 0. Arithmetic is modulo 2^WIDTH.
- Stage k (1..STAGES) adds chunk k-1 (bits [k*CHUNK-1:(k-1)*CHUNK]) using the carry registered by stage k-1.
- Unprocessed upper operand chunks are skewed forward through the stage registers; completed lower result chunks are carried forward with them.
- Each stage register holds: valid, partial result, remaining operands, carry, sub, tag, and the carry into the current MSB position (needed for OF).
- Flags are computed combinationally from the final stage register:
  - OF = carry-into-MSB XOR carry-out-of-MSB.
  - CF = cout XOR sub.
  - ZF = (out_y == 0).
  - SF = MSB of out_y.
- Global advance: adv = !out_valid || out_ready. When adv=1, every stage loads from its predecessor and stage 1 loads the input. When adv=0, all stages hold.
- in_ready = adv && !rst. An input is accepted on a rising edge where in_valid && in_ready.
- Latency: a result accepted at edge N is presented with out_valid=1 after edge N+STAGES-1 (STAGES cycles total). With out_ready held high, throughput is 1 op/cycle.
- Bubbles: a stage loaded from an invalid predecessor clears its valid bit. Bubbles do not block the pipeline, because adv only depends on the output stage.
- Stall: while out_valid && !out_ready, out_y/flags/out_tag are stable, no input is accepted, and no result is lost or duplicated.
- Ordering: results leave strictly in acceptance order, and out_tag always matches the tag of its operands.
- Reset: asserting rst immediately clears all valid bits and zeroes all data, carry and tag registers. While rst is high:
  - out_valid=0, out_y=0, out_tag=0, in_ready=0.
  - Flags follow the zeroed register, giving zf=1 and sf=of=cf=0. Consumers must qualify flags with out_valid.
- Reset mid-stream: in-flight operations are discarded. After rst deasserts, the first result appears STAGES cycles after the next acceptance.
- STAGES=1 degenerates to one registered full-width adder with identical handshake.

Decomposition:
- Shared header alu_defs.vh with include guard, defining:
  - ALU_OP_ADD=1'b0 and ALU_OP_SUB=1'b1.
  - Flag bit indices: ZF=0, SF=1, OF=2, CF=3.
- One sub-module, add_chunk: combinational CHUNK-bit ripple adder built from gate primitives, with ports a, b, cin, y, cout and c_msb (carry into its top bit). It is instantiated STAGES times in a generate loop.

Test Plan (WIDTH=64, STAGES=4):
1. Add, A=0xFFFF_FFFF_FFFF_FFFF, B=1, tag=3, out_ready=1 -> after 4 cycles out_y=0, zf=1, cf=1, of=0, sf=0, out_tag=3.
2. Sub, A=5, B=7 -> out_y=0xFFFF_FFFF_FFFF_FFFE, sf=1, cf=1 (borrow), of=0, zf=0.
3. Add, A=0x7FFF_FFFF_FFFF_FFFF, B=1 -> out_y=0x8000_0000_0000_0000, of=1, sf=1, cf=0. Sub, A=0x8000_0000_0000_0000, B=1 -> out_y=0x7FFF_FFFF_FFFF_FFFF, of=1, cf=0.
4. Eight back-to-back ops, tags 0..7, A=i, B=0x0000_0001_0000_0000 -> eight consecutive out_valid cycles starting at cycle 4, out_y=i+2^32, tags in order 0..7.
5. Full pipeline, out_ready=0 for 3 cycles -> in_ready=0, and out_y/out_tag unchanged during the stall. After release, all 4 results appear in order with no duplicates.
6. rst pulsed for 1 cycle with 3 ops in flight -> out_valid=0 immediately. No stale result follows. A new op issued after reset returns a correct result 4 cycles later.
